// File: rtl/sarcon_reader.sv
// sarcon_reader: sequences a synchronous SAR controller through its track and
// convert phases, captures each settled code and queues it in a small FIFO.
// The FIFO drains over a valid/ready stream.
module sarcon_reader #(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          cont,
    input  logic                          abort,
    input  logic [N-1:0]                  sar_dq,
    input  logic                          sar_last,
    output logic                          sar_rst_n,
    output logic                          sample,
    output logic                          busy,
    output logic [N-1:0]                  m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // Counter reload value: the track phase lasts SAMPLE_CYCLES cycles.
    localparam logic [7:0]    SC_LOAD  = 8'(SAMPLE_CYCLES - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [7:0]     cnt_r;
    logic [7:0]     cnt_next_s;

    logic           sar_rst_n_r;
    logic           sample_r;
    logic           busy_r;

    logic [N-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic [LW-1:0]  level_next_s;
    logic           overflow_r;

    logic           push_req_s;
    logic           push_s;
    logic           pop_s;
    logic           full_s;
    logic           ovf_set_s;
    logic           valid_s;

    // Next-state and sample-counter logic; abort overrides every transition.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_SAMPLE;
                        cnt_next_s   = SC_LOAD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_r == 8'd0) begin
                        state_next_s = ST_CONVERT;
                    end else begin
                        cnt_next_s = cnt_r - 8'd1;
                    end
                end
                ST_CONVERT: begin
                    if (sar_last) begin
                        state_next_s = ST_CAPTURE;
                    end else begin
                        state_next_s = ST_CONVERT;
                    end
                end
                ST_CAPTURE: begin
                    if (cont) begin
                        state_next_s = ST_SAMPLE;
                        cnt_next_s   = SC_LOAD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and the phase outputs, all registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            sar_rst_n_r <= 1'b0;
            sample_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            sar_rst_n_r <= (state_next_s == ST_CONVERT) || (state_next_s == ST_CAPTURE);
            sample_r    <= (state_next_s == ST_SAMPLE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        valid_s    = (level_r != {LW{1'b0}});
        pop_s      = valid_s & m_ready;
        full_s     = (level_r == LVL_FULL);
        push_req_s = (state_r == ST_CAPTURE) & ~abort;
        push_s     = push_req_s & (~full_s | pop_s);
        ovf_set_s  = push_req_s & full_s & ~pop_s;
    end

    // Occupancy update from the accepted push/pop pair.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // FIFO storage, pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {N{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sar_dq;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_next_s;
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign sar_rst_n  = sar_rst_n_r;
    assign sample     = sample_r;
    assign busy       = busy_r;
    assign m_data     = mem_r[rd_ptr_r];
    assign m_valid    = valid_s;
    assign fifo_level = level_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_sarcon_reader.sv
// Directed bench for sarcon_reader with a behavioural SAR controller model
// that resolves one bit per cycle towards a per-conversion target code.
module tb_sarcon_reader;

    localparam int N  = 8;
    localparam int SC = 2;
    localparam int FD = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic          abort = 1'b0;
    logic          m_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [N-1:0]  sar_dq;
    logic          sar_last;
    logic          sar_rst_n;
    logic          sample;
    logic          busy;
    logic [N-1:0]  m_data;
    logic          m_valid;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Target codes, one per conversion that actually leaves SAR reset, in run order.
    logic [7:0] tgt [0:31];

    sarcon_reader #(.N(N), .SAMPLE_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .abort      (abort),
        .sar_dq     (sar_dq),
        .sar_last   (sar_last),
        .sar_rst_n  (sar_rst_n),
        .sample     (sample),
        .busy       (busy),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    // SAR controller model: one edge to set the MSB trial, then one bit per edge.
    function automatic logic [7:0] sar_step(input logic [7:0] dq, input logic [7:0] t, input int b);
        logic [7:0] r;
        r = dq;
        if (r > t) r[b] = 1'b0;
        if (b > 0) r[b-1] = 1'b1;
        return r;
    endfunction

    logic [7:0] m_dq = 8'h00;
    logic [7:0] m_tgt = 8'h00;
    int         m_cnt = 0;
    int         tidx = 0;

    // Behavioural SAR controller with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sar_rst_n) begin
            m_cnt <= 0;
            m_dq  <= 8'h00;
        end else if (m_cnt == 0) begin
            m_dq  <= 8'h80;
            m_cnt <= 1;
            m_tgt <= tgt[tidx];
            tidx  <= tidx + 1;
        end else if (m_cnt <= 8) begin
            m_dq  <= sar_step(m_dq, m_tgt, 8 - m_cnt);
            m_cnt <= m_cnt + 1;
        end
    end

    assign sar_dq   = m_dq;
    assign sar_last = (m_cnt == 8);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int sample_cnt, rstn_cnt, valid_j, nres, idle_cycles, max_level;
    logic [7:0] got;
    logic       busy_at;
    logic [7:0] res_d [0:2];
    int         res_j [0:2];

    initial begin
        tgt[0] = 8'hA5;
        tgt[1] = 8'h00; tgt[2] = 8'hFF; tgt[3] = 8'h3C;
        tgt[4] = 8'h11; tgt[5] = 8'h22; tgt[6] = 8'h33; tgt[7] = 8'h44; tgt[8] = 8'h55;
        tgt[9] = 8'h61; tgt[10] = 8'h62; tgt[11] = 8'h63; tgt[12] = 8'h64; tgt[13] = 8'h65;
        tgt[14] = 8'h77; tgt[15] = 8'h5A; tgt[16] = 8'hC3; tgt[17] = 8'h99;
        for (int i = 18; i < 32; i++) tgt[i] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check_val("rst_sar_rst_n", 32'(sar_rst_n), 32'h0);
        check_val("rst_sample", 32'(sample), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_m_valid", 32'(m_valid), 32'h0);
        check_val("rst_m_data", 32'(m_data), 32'h0);
        check_val("rst_level", 32'(fifo_level), 32'h0);
        check_val("rst_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single shot, target 0xA5; a start pulse mid-conversion must be ignored.
        m_ready = 1'b1;
        pulse_start();
        sample_cnt = 0; rstn_cnt = 0; valid_j = -1; got = 8'h00; busy_at = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 5) start = 1'b1;
            if (j == 6) start = 1'b0;
            if (sample) sample_cnt++;
            if (sar_rst_n && valid_j < 0) rstn_cnt++;
            if (m_valid && valid_j < 0) begin
                valid_j = j; got = m_data; busy_at = busy;
            end
        end
        check_val("ss_sample_cycles", 32'(sample_cnt), 32'd2);
        // 9 convert cycles plus the capture cycle
        check_val("ss_sar_rst_n_cycles", 32'(rstn_cnt), 32'd10);
        check_val("ss_latency", 32'(valid_j), 32'd12);
        check_val("ss_data", 32'(got), 32'hA5);
        check_val("ss_busy_after", 32'(busy_at), 32'h0);

        // Continuous mode: three results 12 cycles apart, never idle in between.
        cont = 1'b1;
        pulse_start();
        nres = 0; idle_cycles = 0;
        for (int j = 0; j < 60 && nres < 3; j++) begin
            if (j > 0) @(negedge clk);
            if (m_valid) begin
                res_d[nres] = m_data; res_j[nres] = j; nres++;
                if (nres == 2) cont = 1'b0;
            end
            if (!busy && nres < 3) idle_cycles++;
        end
        check_val("cont_count", 32'(nres), 32'd3);
        check_val("cont_d0", 32'(res_d[0]), 32'h00);
        check_val("cont_d1", 32'(res_d[1]), 32'hFF);
        check_val("cont_d2", 32'(res_d[2]), 32'h3C);
        check_val("cont_gap01", 32'(res_j[1] - res_j[0]), 32'd12);
        check_val("cont_gap12", 32'(res_j[2] - res_j[1]), 32'd12);
        check_val("cont_idle", 32'(idle_cycles), 32'd0);
        repeat (3) @(negedge clk);

        // Backpressure until the fifth result is dropped.
        m_ready = 1'b0; cont = 1'b1;
        pulse_start();
        max_level = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (overflow) break;
        end
        abort = 1'b1; cont = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check_val("bp_overflow", 32'(overflow), 32'h1);
        check_val("bp_max_level", 32'(max_level), 32'd4);
        check_val("bp_level", 32'(fifo_level), 32'd4);
        check_val("bp_head_stable", 32'(m_data), 32'h11);
        check_val("bp_abort_idle", 32'(busy), 32'h0);
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val("bp_drain_valid", 32'(m_valid), 32'h1);
            check_val("bp_drain_data", 32'(m_data), 32'(tgt[4+k]));
            @(negedge clk);
        end
        m_ready = 1'b0;
        check_val("bp_empty_level", 32'(fifo_level), 32'd0);
        check_val("bp_empty_valid", 32'(m_valid), 32'h0);
        check_val("bp_ovf_sticky", 32'(overflow), 32'h1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check_val("bp_ovf_clear", 32'(overflow), 32'h0);

        // Full FIFO with a pop on the capture exit edge.
        cont = 1'b1;
        pulse_start();
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (fifo_level == 3'd4) break;
        end
        cont = 1'b0;
        repeat (11) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_val("fp_level", 32'(fifo_level), 32'd4);
        check_val("fp_overflow", 32'(overflow), 32'h0);
        check_val("fp_head", 32'(m_data), 32'h62);
        check_val("fp_busy", 32'(busy), 32'h0);
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val("fp_drain_data", 32'(m_data), 32'(tgt[10+k]));
            @(negedge clk);
        end
        m_ready = 1'b0;
        check_val("fp_empty_level", 32'(fifo_level), 32'd0);

        // One normal result held in the FIFO, then abort at the fourth bit.
        pulse_start();
        repeat (13) @(negedge clk);
        check_val("ab_pre_level", 32'(fifo_level), 32'd1);
        check_val("ab_pre_data", 32'(m_data), 32'h77);
        pulse_start();
        repeat (6) @(negedge clk);
        check_val("ab_in_convert", 32'(sar_rst_n), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("ab_busy", 32'(busy), 32'h0);
        check_val("ab_sar_rst_n", 32'(sar_rst_n), 32'h0);
        check_val("ab_level", 32'(fifo_level), 32'd1);
        repeat (10) @(negedge clk);
        check_val("ab_no_push", 32'(fifo_level), 32'd1);
        pulse_start();
        repeat (13) @(negedge clk);
        check_val("ab_after_level", 32'(fifo_level), 32'd2);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_val("ab_after_data", 32'(m_data), 32'hC3);
        pulse_start();
        repeat (13) @(negedge clk);
        check_val("ar_pre_level", 32'(fifo_level), 32'd2);

        // Asynchronous reset in the track phase.
        pulse_start();
        check_val("ar_in_sample", 32'(sample), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_sample", 32'(sample), 32'h0);
        check_val("ar_busy", 32'(busy), 32'h0);
        check_val("ar_sar_rst_n", 32'(sar_rst_n), 32'h0);
        check_val("ar_m_valid", 32'(m_valid), 32'h0);
        check_val("ar_m_data", 32'(m_data), 32'h0);
        check_val("ar_level", 32'(fifo_level), 32'd0);
        check_val("ar_overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("ar_stays_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
